spi_apb_master: RTL and testbench
=================================

Name: spi_apb_master

Overview:
- Debug-link front end and APB master for the debugger APB slave: PSEL/PADDR/PENABLE/PWRITE/PWDATA out, PRDATA/PREADY in.
- Receives SPI mode-0 frames from an external host, MSB first. All logic runs on PCLK; SCK/CS_N/MOSI are oversampled.
- Each frame is one command byte followed by N data bytes, with APB address auto-increment (burst).

Parameters:
- SYNC_STAGES, 2, flops per SPI input synchroniser (minimum 2).
- ADDR_W, 5, APB address width.

Ports:
- PCLK  in  1  system/APB clock.
- PRESET  in  1  reset, asynchronous, active-high.
- SPI_SCK  in  1  host serial clock, async to PCLK.
- SPI_CS_N  in  1  host chip select, active low.
- SPI_MOSI  in  1  host data in.
- SPI_MISO  out  1  read data to host.
- PSEL  out  1  APB select.
- PADDR  out  ADDR_W  APB address.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction (1 = write).
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- PREADY  in  1  APB ready.
- BUSY  out  1  high while the frame or an APB transfer is active.
- ERR  out  1  sticky overrun flag.

Behaviour:
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, SPI_MISO, BUSY, ERR all 0. FSM = IDLE, bit_cnt = 0, shift regs = 0. Reset acts at any time, including mid-APB; outputs go to reset values at once.
- Sync/edge detect: SCK, CS_N and MOSI each pass SYNC_STAGES flops. Edges are detected on the synced SCK. MOSI is sampled on a synced SCK rise.
- Host timing contract: SCK high and low phases >= 8 PCLK each; CS_N setup/hold >= 8 PCLK.
- bit_cnt (3b): increments on each SCK rise while CS active; wraps 7->0 = byte complete. A CS_N fall clears bit_cnt and ERR.
- Command byte: bit7 = write, bits[6:5] ignored, bits[4:0] = start address.
- FSM states: IDLE, CMD, RD_SETUP, RD_ACCESS, DATA, WR_SETUP, WR_ACCESS, DRAIN.
- IDLE -> CMD on synced CS_N fall.
- CMD:
  - On byte complete, latch addr and dir.
  - Read: go to RD_SETUP.
  - Write: go to DATA.
- RD_SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE=0, PADDR=addr.
- RD_ACCESS: PENABLE=1; hold until PREADY. On PREADY:
  - load tx_sr <= PRDATA;
  - addr <= addr+1, wrapping 31->0;
  - drop PSEL/PENABLE the next cycle; go to DATA.
- WR_SETUP (1 cycle): PSEL=1, PWRITE=1, PENABLE=0, PADDR=addr, PWDATA=rx byte.
- WR_ACCESS: PENABLE=1 until PREADY, then addr++ (wrap), release bus, go to DATA.
- DATA:
  - Read frame: SPI_MISO = tx_sr[7]. tx_sr shifts left on each SCK fall with bit_cnt != 0; the fall right after byte complete is ignored. On byte complete, go to RD_SETUP (prefetch of the next address; this read occurs even if the host ends the frame).
  - Write frame: rx_sr shifts on SCK rise. On byte complete, go to WR_SETUP.
- SPI_MISO is 0 in every state other than DATA-read.
- Overrun:
  - Read: an SCK rise arrives while in RD_SETUP/RD_ACCESS (data not yet loaded). Set ERR; the host receives stale tx_sr bits.
  - Write: a byte completes while in WR_SETUP/WR_ACCESS. Set ERR; that byte is dropped.
- CS_N rise:
  - In CMD/DATA: discard any partial byte; no APB transfer; go to IDLE.
  - In *_SETUP/*_ACCESS: go to DRAIN; the APB transfer completes normally (PREADY honoured, read data discarded); then IDLE.
- APB compliance: PADDR/PWRITE/PWDATA stable from SETUP through the PREADY cycle. PENABLE is never high without PSEL. Back-to-back transfers always return to PSEL=0 for at least 1 cycle.
- BUSY = (FSM != IDLE).
- Latency: synced byte-complete -> PSEL high = 1 PCLK. Zero-wait read -> tx_sr loaded 2 PCLK after PSEL rise.

Test Plan:
- Write cmd 0x80, data 0x5A -> one APB write: PADDR=0, PWDATA=0x5A, PWRITE=1, 1 setup + 1 access cycle; ERR=0.
- Read cmd 0x18 + 4 data bytes, PREADY tied 1, slave returns 42/45/2D/38 at 0x18-0x1B -> MISO bytes 0x42,0x45,0x2D,0x38; 5 APB reads; last read (0x1C) is the prefetch.
- Burst write cmd 0x9F, data 0x11,0x22 -> writes at PADDR 0x1F then 0x00 (wrap).
- Read with 3 PREADY wait states at SCK half-period 8 PCLK -> PENABLE held 4 cycles; correct MISO byte; ERR=0. Raise wait states to 20 -> ERR=1.
- CS_N released after 5 bits of a write data byte -> no APB write; IDLE; BUSY=0. CS_N released during RD_ACCESS with PREADY delayed 6 cycles -> transfer completes, then IDLE.
- PRESET pulsed during WR_ACCESS -> PSEL/PENABLE low immediately; next frame executes normally.

Source files
------------

// File: rtl/spi_apb_master.sv
// SPI (mode 0, MSB first) debug-link front end driving an APB master.
// A frame is one command byte {write, 2'bx, start_addr[4:0]} followed by
// data bytes; every data byte is one APB transfer at an auto-incremented
// address. All SPI pins are oversampled on PCLK.
`timescale 1ns/1ps
module spi_apb_master #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              SPI_SCK,
    input  logic              SPI_CS_N,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              PSEL,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PWDATA,
    input  logic [7:0]        PRDATA,
    input  logic              PREADY,
    output logic              BUSY,
    output logic              ERR
);

    typedef enum logic [2:0] {
        IDLE, CMD, RD_SETUP, RD_ACCESS, DATA, WR_SETUP, WR_ACCESS, DRAIN
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sr;
    logic [7:0]             tx_sr;
    logic [ADDR_W-1:0]      addr;
    logic                   wr;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, cs_fall, cs_active;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic       rd_overrun, wr_overrun;

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_active = ~cs_s;
    assign byte_done = sck_rise & cs_active & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr[6:0], mosi_s};

    // A host edge that lands while the bus is still fetching/writing the
    // previous byte means the host is outrunning the slave.
    assign rd_overrun = sck_rise & cs_active & ((state == RD_SETUP) | (state == RD_ACCESS));
    assign wr_overrun = byte_done & ((state == WR_SETUP) | (state == WR_ACCESS));

    assign SPI_MISO = ((state == DATA) && !wr) ? tx_sr[7] : 1'b0;
    assign BUSY     = (state != IDLE);

    // Synchronise host pins; CS_N resets to the inactive level so that leaving
    // reset never looks like a chip-select edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS_N};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    // Count bits within the frame and assemble the incoming byte.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
        end else begin
            if (cs_fall)
                bit_cnt <= '0;
            else if (sck_rise && cs_active)
                bit_cnt <= bit_cnt + 3'd1;
            if (sck_rise && cs_active)
                rx_sr <= rx_byte;
        end
    end

    // Frame/APB sequencer with registered bus outputs, read shifter and error flag.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            addr    <= '0;
            wr      <= 1'b0;
            tx_sr   <= '0;
            ERR     <= 1'b0;
        end else begin
            if (cs_fall)
                ERR <= 1'b0;
            else if (rd_overrun || wr_overrun)
                ERR <= 1'b1;

            // The fall right after a completed byte (bit_cnt == 0) belongs to the
            // gap where the next byte is being fetched, so it must not shift.
            if (state == DATA && !wr && sck_fall && bit_cnt != 3'd0)
                tx_sr <= {tx_sr[6:0], 1'b0};

            case (state)
                IDLE: begin
                    if (cs_fall)
                        state <= CMD;
                end
                CMD: begin
                    if (!cs_active) begin
                        state <= IDLE;
                    end else if (byte_done) begin
                        addr <= ADDR_W'(rx_byte[4:0]);
                        wr   <= rx_byte[7];
                        if (rx_byte[7]) begin
                            state <= DATA;
                        end else begin
                            state  <= RD_SETUP;
                            PSEL   <= 1'b1;
                            PWRITE <= 1'b0;
                            PADDR  <= ADDR_W'(rx_byte[4:0]);
                        end
                    end
                end
                DATA: begin
                    if (!cs_active) begin
                        state <= IDLE;
                    end else if (byte_done) begin
                        PSEL  <= 1'b1;
                        PADDR <= addr;
                        if (wr) begin
                            state  <= WR_SETUP;
                            PWRITE <= 1'b1;
                            PWDATA <= rx_byte;
                        end else begin
                            // Prefetch the next address while the host clocks out this one.
                            state  <= RD_SETUP;
                            PWRITE <= 1'b0;
                        end
                    end
                end
                RD_SETUP, WR_SETUP: begin
                    PENABLE <= 1'b1;
                    if (!cs_active)
                        state <= DRAIN;
                    else if (state == WR_SETUP)
                        state <= WR_ACCESS;
                    else
                        state <= RD_ACCESS;
                end
                RD_ACCESS, WR_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        addr    <= addr + ADDR_W'(1);
                        if (state == RD_ACCESS)
                            tx_sr <= PRDATA;
                        state <= cs_active ? DATA : IDLE;
                    end else if (!cs_active) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Frame is over; finish the bus transfer cleanly and drop read data.
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_apb_master.sv
// Self-checking bench for spi_apb_master: SPI host driver, APB slave memory,
// frame-level reference model and queue-based scoreboards for APB and MISO.
`timescale 1ns/1ps
module tb_spi_apb_master;

    localparam int H = 8;   // SCK half period in PCLK cycles

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       SPI_SCK, SPI_CS_N, SPI_MOSI, SPI_MISO;
    logic       PSEL, PENABLE, PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = 8'h00;
    logic       PREADY = 1'b0;
    logic       BUSY, ERR;

    spi_apb_master #(.SYNC_STAGES(2), .ADDR_W(5)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .SPI_SCK(SPI_SCK), .SPI_CS_N(SPI_CS_N), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
        .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
        int         pen;
    } apb_exp_t;

    typedef struct {
        logic [7:0] val;
        logic       dc;
    } miso_exp_t;

    apb_exp_t  apb_q[$];
    miso_exp_t miso_q[$];
    int        checks = 0;
    int        failures = 0;
    logic [7:0] slave_mem[32];
    logic [7:0] model_mem[32];
    logic [7:0] frame_data[8];
    int        waits = 0;

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // APB slave with programmable wait states, plus transfer monitor.
    int         acc_cnt = 0, setup_cnt = 0, pen_cnt = 0;
    logic       idle_seen = 1'b1, setup_after_idle = 1'b0;
    logic [4:0] s_addr;
    logic       s_wr;
    logic [7:0] s_data;

    always @(negedge PCLK) begin
        if (!PSEL) begin
            PREADY = 1'b0;
            acc_cnt = 0; setup_cnt = 0; pen_cnt = 0;
            idle_seen = 1'b1;
        end else if (!PENABLE) begin
            PREADY = 1'b0;
            setup_cnt++;
            setup_after_idle = idle_seen;
            s_addr = PADDR; s_wr = PWRITE; s_data = PWDATA;
        end else begin
            pen_cnt++;
            PRDATA = slave_mem[PADDR];
            PREADY = (acc_cnt >= waits);
            if (!PREADY) begin
                acc_cnt++;
            end else begin
                if (apb_q.size() == 0) begin
                    check("apb_unexpected", 1'b0, {PWRITE, PADDR}, 0);
                end else begin
                    apb_exp_t   e;
                    logic [31:0] act, exp;
                    logic        stable;
                    e = apb_q.pop_front();
                    act = {8'(pen_cnt), 3'(setup_cnt), setup_after_idle, 3'b0, PWRITE, 3'b0, PADDR,
                           (e.wr ? PWDATA : 8'h00)};
                    exp = {8'(e.pen), 3'd1, 1'b1, 3'b0, e.wr, 3'b0, e.addr, (e.wr ? e.data : 8'h00)};
                    stable = (PADDR == s_addr) && (PWRITE == s_wr) && (PWDATA == s_data);
                    check("apb_xfer", (act == exp) && stable, act, exp);
                end
                if (PWRITE) slave_mem[PADDR] = PWDATA;
                acc_cnt = 0; setup_cnt = 0; pen_cnt = 0;
                idle_seen = 1'b0;
            end
        end
    end

    // MISO monitor: collects each full byte the host clocks in and scores it.
    int         mbits = 0;
    logic [7:0] mbyte = 8'h00;

    always @(posedge SPI_SCK or posedge SPI_CS_N) begin
        if (SPI_CS_N) begin
            mbits = 0;
        end else begin
            mbyte = {mbyte[6:0], SPI_MISO};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (miso_q.size() == 0) begin
                    check("miso_unexpected", 1'b0, mbyte, 0);
                end else begin
                    miso_exp_t m;
                    m = miso_q.pop_front();
                    if (!m.dc) check("miso_byte", mbyte == m.val, mbyte, m.val);
                end
            end
        end
    end

    // Host driver helpers.
    task automatic sck_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            SPI_MOSI = b[i];
            repeat (H) @(negedge PCLK);
            SPI_SCK = 1'b1;
            repeat (H) @(negedge PCLK);
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge PCLK);
        SPI_CS_N = 1'b0;
        repeat (10) @(negedge PCLK);
    endtask

    task automatic cs_high(input int settle);
        repeat (10) @(negedge PCLK);
        SPI_CS_N = 1'b1;
        repeat (settle) @(negedge PCLK);
    endtask

    // Reference model: a read frame of n bytes from A returns mem[A..A+n-1]
    // and issues n+1 reads (the last one is the prefetch); a write frame
    // issues n writes. Addresses wrap modulo 32.
    task automatic run_frame(input logic [7:0] cmd, input int n, input int w,
                             input logic dc, input logic exp_err);
        logic [4:0] a;
        logic [4:0] ai;
        a = cmd[4:0];
        waits = w;
        miso_q.push_back('{val: 8'h00, dc: 1'b0});
        if (cmd[7]) begin
            for (int i = 0; i < n; i++) begin
                ai = 5'(a + i);
                apb_q.push_back('{wr: 1'b1, addr: ai, data: frame_data[i], pen: w + 1});
                model_mem[ai] = frame_data[i];
                miso_q.push_back('{val: 8'h00, dc: 1'b0});
            end
        end else begin
            for (int i = 0; i <= n; i++) begin
                ai = 5'(a + i);
                apb_q.push_back('{wr: 1'b0, addr: ai, data: 8'h00, pen: w + 1});
                if (i < n) miso_q.push_back('{val: model_mem[ai], dc: dc});
            end
        end
        cs_low();
        sck_bits(cmd, 8);
        for (int i = 0; i < n; i++)
            sck_bits(cmd[7] ? frame_data[i] : 8'($urandom), 8);
        cs_high(30);
        check("busy_after_frame", BUSY == 1'b0, BUSY, 0);
        check("err_after_frame", ERR == exp_err, ERR, exp_err);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int t;
        for (int i = 0; i < 32; i++) begin
            v = 8'($urandom);
            slave_mem[i] = v;
            model_mem[i] = v;
        end
        slave_mem[5'h18] = 8'h42; model_mem[5'h18] = 8'h42;
        slave_mem[5'h19] = 8'h45; model_mem[5'h19] = 8'h45;
        slave_mem[5'h1A] = 8'h2D; model_mem[5'h1A] = 8'h2D;
        slave_mem[5'h1B] = 8'h38; model_mem[5'h1B] = 8'h38;

        PRESET = 1'b1; SPI_SCK = 1'b0; SPI_CS_N = 1'b1; SPI_MOSI = 1'b0;
        repeat (3) @(negedge PCLK);
        check("reset_state", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, SPI_MISO, BUSY, ERR} == 19'd0,
              {PSEL, PENABLE, PWRITE, PADDR, PWDATA, SPI_MISO, BUSY, ERR}, 0);
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);

        // Single write at address 0.
        frame_data[0] = 8'h5A;
        run_frame(8'h80, 1, 0, 1'b0, 1'b0);

        // Four-byte read burst from 0x18 plus prefetch of 0x1C.
        run_frame(8'h18, 4, 0, 1'b0, 1'b0);

        // Write burst wrapping from 0x1F to 0x00.
        frame_data[0] = 8'h11; frame_data[1] = 8'h22;
        run_frame(8'h9F, 2, 0, 1'b0, 1'b0);
        run_frame(8'h1F, 2, 0, 1'b0, 1'b0);

        // Three wait states are absorbed; twenty cause an overrun.
        run_frame(8'h03, 1, 3, 1'b0, 1'b0);
        run_frame(8'h07, 1, 20, 1'b1, 1'b1);
        // Next frame's chip-select clears the sticky error.
        run_frame(8'h08, 1, 0, 1'b0, 1'b0);

        // Chip-select released after five bits of a write data byte.
        waits = 0;
        miso_q.push_back('{val: 8'h00, dc: 1'b0});
        cs_low();
        sck_bits(8'h84, 8);
        sck_bits(8'hC3, 5);
        cs_high(30);
        check("abort_idle", (BUSY == 1'b0) && (PSEL == 1'b0), {BUSY, PSEL}, 0);
        run_frame(8'h04, 1, 0, 1'b0, 1'b0);

        // Chip-select released while a slow read is in its access phase.
        waits = 25;
        miso_q.push_back('{val: 8'h00, dc: 1'b0});
        apb_q.push_back('{wr: 1'b0, addr: 5'h0A, data: 8'h00, pen: 26});
        cs_low();
        sck_bits(8'h0A, 8);
        repeat (10) @(negedge PCLK);
        SPI_CS_N = 1'b1;
        repeat (4) @(negedge PCLK);
        check("drain_active", BUSY && PSEL && PENABLE, {BUSY, PSEL, PENABLE}, 3'b111);
        repeat (30) @(negedge PCLK);
        check("drain_done", BUSY == 1'b0, BUSY, 0);

        // Reset pulsed during a write access: bus released immediately.
        waits = 40;
        miso_q.push_back('{val: 8'h00, dc: 1'b0});
        miso_q.push_back('{val: 8'h00, dc: 1'b0});
        cs_low();
        sck_bits(8'h8C, 8);
        sck_bits(8'hE7, 8);
        t = 0;
        while (!(PSEL && PENABLE) && t < 100) begin
            @(negedge PCLK);
            t++;
        end
        check("rst_reach_access", PSEL && PENABLE && PWRITE, {PSEL, PENABLE, PWRITE}, 3'b111);
        repeat (2) @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1 check("rst_async", {PSEL, PENABLE, BUSY} == 3'b000, {PSEL, PENABLE, BUSY}, 0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        cs_high(30);
        check("rst_idle", BUSY == 1'b0, BUSY, 0);
        frame_data[0] = 8'h96;
        run_frame(8'h8C, 1, 1, 1'b0, 1'b0);
        run_frame(8'h0C, 1, 0, 1'b0, 1'b0);

        // Randomised frames against the model.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] cmd;
            int n;
            cmd = {1'($urandom), 2'($urandom), 5'($urandom)};
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) frame_data[i] = 8'($urandom);
            run_frame(cmd, n, $urandom_range(0, 3), 1'b0, 1'b0);
        end

        repeat (20) @(negedge PCLK);
        check("apb_queue_drained", apb_q.size() == 0, apb_q.size(), 0);
        check("miso_queue_drained", miso_q.size() == 0, miso_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
